snd_cmd_queue: RTL and testbench
================================

// Module: snd_cmd_queue
// PURPOSE
//  Buffered sound-command interface between the main CPU and the sound Z80.
//  Queues up to 2**DEPTH_LOG2 command bytes. Presents them one at a time on comlatch,
//  each announced by an NMI. Also generates the periodic sound-CPU IRQ at a
//  parametrised rate. Successor to the single-latch play-request block.
// PARAMETERS
//  DW          8      command width, bits
//  DEPTH_LOG2  2      FIFO depth = 2**DEPTH_LOG2 entries (1..4)
//  IRQ_PERIOD  33333  clk_en ticks between IRQ requests (>=2); 33333 @8MHz = 240Hz
// PORTS
//  clk48M     in   1           system clock
//  reset      in   1           asynchronous, active-high
//  clk_en     in   1           timer tick enable (8MHz strobe)
//  sndno      in   DW          command from main CPU
//  sndstart   in   1           command strobe; rising edge = push
//  latch_rd   in   1           sound CPU read of latch (1-cycle pulse); releases entry
//  cpu_irq    out  1           periodic IRQ request
//  cpu_irqa   in   1           IRQ acknowledge
//  cpu_nmi    out  1           command-pending NMI
//  cpu_nmia   in   1           NMI acknowledge
//  comlatch   out  DW          current command byte
//  q_count    out  DEPTH_LOG2+1  queued entries (excludes comlatch)
//  q_ovf      out  1           sticky: push attempted while FIFO full
// BEHAVIOUR
//  Reset: cpu_irq=0, cpu_nmi=0, comlatch=0, q_count=0, q_ovf=0.
//    Also timer=0, FIFO pointers=0, edge register=0, FSM=IDLE.
//  Command path runs every clk48M cycle. Only the timer is gated by clk_en.
//  Push = registered rising edge of sndstart.
//    Applied the cycle after the edge is seen.
//  FSM:
//    IDLE : push -> comlatch<=sndno, cpu_nmi<=1, -> PEND.
//           FIFO is always empty in IDLE.
//    PEND : cpu_nmia -> cpu_nmi<=0, -> ACKD. Pushes go to FIFO.
//    ACKD : latch_rd -> if FIFO non-empty: pop to comlatch, cpu_nmi<=1, -> PEND.
//           Else -> IDLE; comlatch holds its last value.
//  latch_rd in IDLE or PEND: ignored.
//  cpu_nmia outside PEND: ignored.
//  FIFO full + push, no pop that cycle: byte dropped, q_ovf<=1.
//  FIFO full + push + pop same cycle: pop first, push accepted, q_count unchanged.
//  Pointers wrap modulo 2**DEPTH_LOG2; q_count = wr_ptr - rd_ptr on DEPTH_LOG2+1 bits.
//  Timer: on clk_en, cnt <= (cnt==IRQ_PERIOD-1) ? 0 : cnt+1.
//    On wrap, cpu_irq<=1.
//  cpu_irqa clears cpu_irq on any cycle.
//  Set and ack in the same cycle: set wins (IRQ stays high).
//  Reset mid-operation: everything returns to reset values; queued bytes are lost.
// CONFIGURATION
//  SNDQ_STATUS_EN defined:
//    Adds input ovf_clr (1-cycle pulse; clears q_ovf, lower priority than a new overflow).
//    Adds output snd_status[7:0] = {q_ovf, full, empty, fsm[1:0], 3'b0}.
//    fsm encoding: IDLE=0, PEND=1, ACKD=2.
//  Undefined: neither port exists; q_ovf is cleared only by reset.
// TESTING
//  1 Single cmd: sndno=8'h42 edge in IDLE -> next cycle comlatch=42, nmi=1.
//    nmia -> nmi=0. latch_rd -> IDLE, comlatch stays 42.
//  2 Burst: 3 edges (11,22,33) before any ack -> comlatch=11, q_count=2.
//    Each nmia+latch_rd pair advances comlatch: 22, then 33. Finally q_count=0.
//  3 Overflow (DEPTH_LOG2=2): 6 pushes without read -> latch holds 1 byte, FIFO 4, q_ovf=1.
//    The 6th byte never appears on comlatch.
//  4 Full + pop + push same cycle -> q_count stays 4, new byte delivered last, q_ovf=0.
//  5 Timer, IRQ_PERIOD=4, clk_en every cycle -> cpu_irq rises every 4 ticks.
//    Ack coincident with a wrap leaves irq=1.
//  6 Reset asserted in PEND with q_count=2 -> all outputs 0 immediately (async).
//    A fresh push after release behaves as in test 1.

Source files
------------

// File: rtl/snd_cmd_queue.sv
// snd_cmd_queue: sound-command FIFO with NMI handshake and periodic sound-CPU IRQ timer.
// Optional status port (ovf_clr, snd_status) enabled by defining SNDQ_STATUS_EN.
module snd_cmd_queue #(
  parameter int DW         = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter int IRQ_PERIOD = 33333
) (
  input  logic                  clk48M,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic [DW-1:0]         sndno,
  input  logic                  sndstart,
  input  logic                  latch_rd,
  output logic                  cpu_irq,
  input  logic                  cpu_irqa,
  output logic                  cpu_nmi,
  input  logic                  cpu_nmia,
  output logic [DW-1:0]         comlatch,
  output logic [DEPTH_LOG2:0]   q_count,
  output logic                  q_ovf
`ifdef SNDQ_STATUS_EN
  ,
  input  logic                  ovf_clr,
  output logic [7:0]            snd_status
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW = $clog2(IRQ_PERIOD);
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, ACKD = 2'd2} state_t;
  state_t state_q, state_d;
  logic start_q;
  logic [DEPTH_LOG2:0] wr_q, wr_d, rd_q, rd_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] latch_q, latch_d;
  logic nmi_q, nmi_d, irq_q, irq_d, ovf_q, ovf_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic push, pop, bypass, fifo_wr, accept, full, empty, wrap, ovf_clr_i;
`ifdef SNDQ_STATUS_EN
  assign ovf_clr_i = ovf_clr;
  assign snd_status = {ovf_q, full, empty, state_q, 3'b0};
`else
  assign ovf_clr_i = 1'b0;
`endif
  assign q_count = wr_q - rd_q;
  assign full = q_count == (DEPTH_LOG2+1)'(DEPTH);
  assign empty = q_count == '0;
  assign comlatch = latch_q;
  assign cpu_nmi = nmi_q;
  assign cpu_irq = irq_q;
  assign q_ovf = ovf_q;
  always_comb begin
    push = sndstart & ~start_q;
    pop = state_q == ACKD && latch_rd && !empty;
    // a push arriving as the last entry is released goes straight to the latch
    bypass = state_q == ACKD && latch_rd && empty;
    fifo_wr = push && state_q != IDLE && !bypass;
    accept = fifo_wr && (!full || pop);
    state_d = state_q;
    latch_d = latch_q;
    nmi_d = nmi_q;
    if (state_q == IDLE && push) begin
      latch_d = sndno;
      nmi_d = 1'b1;
      state_d = PEND;
    end else if (state_q == PEND && cpu_nmia) begin
      nmi_d = 1'b0;
      state_d = ACKD;
    end else if (state_q == ACKD && latch_rd) begin
      latch_d = pop ? mem_q[rd_q[DEPTH_LOG2-1:0]] : push ? sndno : latch_q;
      nmi_d = pop || push;
      state_d = (pop || push) ? PEND : IDLE;
    end
    mem_d = mem_q;
    if (accept) mem_d[wr_q[DEPTH_LOG2-1:0]] = sndno;
    wr_d = wr_q + (DEPTH_LOG2+1)'(accept);
    rd_d = rd_q + (DEPTH_LOG2+1)'(pop);
    ovf_d = (fifo_wr && !accept) | (ovf_q & ~ovf_clr_i);
    wrap = clk_en && cnt_q == TW'(IRQ_PERIOD-1);
    cnt_d = !clk_en ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
    irq_d = wrap | (irq_q & ~cpu_irqa);
  end
  always_ff @(posedge clk48M or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      mem_q <= '{default: '0};
      latch_q <= '0;
      nmi_q <= 1'b0;
      irq_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= sndstart;
      wr_q <= wr_d;
      rd_q <= rd_d;
      mem_q <= mem_d;
      latch_q <= latch_d;
      nmi_q <= nmi_d;
      irq_q <= irq_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_snd_cmd_queue.sv
// tb_snd_cmd_queue: directed scenarios plus random traffic checked against a queue-based model.
module tb_snd_cmd_queue;
  logic clk48M = 1'b0, reset = 1'b1, clk_en = 1'b0;
  logic [7:0] sndno = '0, comlatch;
  logic sndstart = 1'b0, latch_rd = 1'b0, cpu_irq, cpu_irqa = 1'b0, cpu_nmi, cpu_nmia = 1'b0, q_ovf;
  logic [2:0] q_count;
  int total = 0, bad = 0;
  byte unsigned m_fifo[$];
  logic [7:0] m_latch;
  int m_mode, m_t;
  logic m_nmi, m_irq, m_ovf, m_prev;
  snd_cmd_queue #(.DW(8), .DEPTH_LOG2(2), .IRQ_PERIOD(4)) dut (
    .clk48M(clk48M), .reset(reset), .clk_en(clk_en), .sndno(sndno), .sndstart(sndstart),
    .latch_rd(latch_rd), .cpu_irq(cpu_irq), .cpu_irqa(cpu_irqa), .cpu_nmi(cpu_nmi),
    .cpu_nmia(cpu_nmia), .comlatch(comlatch), .q_count(q_count), .q_ovf(q_ovf));
  always #5 clk48M = ~clk48M;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic compare_all();
    chk("comlatch", 32'(comlatch), 32'(m_latch));
    chk("nmi", 32'(cpu_nmi), 32'(m_nmi));
    chk("q_count", 32'(q_count), 32'(m_fifo.size()));
    chk("q_ovf", 32'(q_ovf), 32'(m_ovf));
    chk("irq", 32'(cpu_irq), 32'(m_irq));
  endtask
  task automatic model_reset();
    m_fifo.delete();
    m_latch = '0; m_mode = 0; m_t = 0;
    m_nmi = 0; m_irq = 0; m_ovf = 0; m_prev = 0;
  endtask
  task automatic fifo_add(input logic [7:0] b);
    if (m_fifo.size() < 4) m_fifo.push_back(b);
    else m_ovf = 1;
  endtask
  // mode 0 = waiting for a command, 1 = NMI raised, 2 = NMI acked, awaiting read
  task automatic model_update(input logic s, input logic [7:0] sno, input logic rd, na, ia, ce);
    logic push, wrap;
    push = s && !m_prev;
    m_prev = s;
    if (m_mode == 0) begin
      if (push) begin m_latch = sno; m_nmi = 1; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (na) begin m_nmi = 0; m_mode = 2; end
      if (push) fifo_add(sno);
    end else if (rd) begin
      if (m_fifo.size() > 0) begin
        m_latch = m_fifo.pop_front(); m_nmi = 1; m_mode = 1;
        if (push) fifo_add(sno);
      end else if (push) begin
        m_latch = sno; m_nmi = 1; m_mode = 1;
      end else m_mode = 0;
    end else if (push) fifo_add(sno);
    wrap = 0;
    if (ce) begin m_t = (m_t + 1) % 4; wrap = m_t == 0; end
    m_irq = wrap ? 1'b1 : ia ? 1'b0 : m_irq;
  endtask
  task automatic step(input logic s, input logic [7:0] sno, input logic rd = 0, na = 0, ia = 0, ce = 0);
    @(negedge clk48M);
    sndstart = s; sndno = sno; latch_rd = rd; cpu_nmia = na; cpu_irqa = ia; clk_en = ce;
    @(posedge clk48M);
    model_update(s, sno, rd, na, ia, ce);
    #1 compare_all();
  endtask
  task automatic push_cmd(input logic [7:0] b);
    step(1, b);
    step(0, b);
  endtask
  task automatic do_reset();
    @(negedge clk48M);
    reset = 1;
    sndstart = 0; latch_rd = 0; cpu_nmia = 0; cpu_irqa = 0; clk_en = 0;
    model_reset();
    #1 compare_all();
    @(negedge clk48M);
    reset = 0;
  endtask
  initial begin
    do_reset();
    // single command
    step(1, 8'h42);
    chk("t1_latch", 32'(comlatch), 32'h42);
    chk("t1_nmi", 32'(cpu_nmi), 1);
    step(0, 8'h42, 0, 1);
    chk("t1_nmi_ack", 32'(cpu_nmi), 0);
    step(0, 8'h00, 1);
    chk("t1_hold", 32'(comlatch), 32'h42);
    step(0, 8'h00, 1, 1);
    chk("t1_idle_ignore", 32'(cpu_nmi), 0);
    // burst
    push_cmd(8'h11); push_cmd(8'h22); push_cmd(8'h33);
    chk("t2_latch", 32'(comlatch), 32'h11);
    chk("t2_count", 32'(q_count), 2);
    step(0, 0, 0, 1); step(0, 0, 1);
    chk("t2_second", 32'(comlatch), 32'h22);
    step(0, 0, 0, 1); step(0, 0, 1);
    chk("t2_third", 32'(comlatch), 32'h33);
    chk("t2_empty", 32'(q_count), 0);
    // overflow
    do_reset();
    for (int i = 1; i <= 6; i++) push_cmd(8'(8'hA0 + i));
    chk("t3_count", 32'(q_count), 4);
    chk("t3_ovf", 32'(q_ovf), 1);
    chk("t3_latch", 32'(comlatch), 32'hA1);
    for (int i = 0; i < 5; i++) begin step(0, 0, 0, 1); step(0, 0, 1); end
    chk("t3_last", 32'(comlatch), 32'hA5);
    // full + pop + push in the same cycle
    do_reset();
    for (int i = 1; i <= 5; i++) push_cmd(8'(8'hB0 + i));
    step(0, 0, 0, 1);
    step(1, 8'hEE, 1);
    chk("t4_count", 32'(q_count), 4);
    chk("t4_ovf", 32'(q_ovf), 0);
    step(0, 8'hEE);
    for (int i = 0; i < 4; i++) begin step(0, 0, 0, 1); step(0, 0, 1); end
    chk("t4_last", 32'(comlatch), 32'hEE);
    // timer
    do_reset();
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 0, 1);
    chk("t5_rise", 32'(cpu_irq), 1);
    step(0, 0, 0, 0, 1, 1);
    chk("t5_ack", 32'(cpu_irq), 0);
    step(0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("t5_ack_vs_wrap", 32'(cpu_irq), 1);
    // async reset in PEND with two queued
    push_cmd(8'h01); push_cmd(8'h02); push_cmd(8'h03);
    chk("t6_pre", 32'(q_count), 2);
    @(negedge clk48M);
    reset = 1;
    model_reset();
    #1 compare_all();
    chk("t6_latch0", 32'(comlatch), 0);
    @(negedge clk48M);
    reset = 0;
    step(1, 8'h42);
    chk("t6_fresh", 32'(comlatch), 32'h42);
    chk("t6_fresh_nmi", 32'(cpu_nmi), 1);
    step(0, 8'h42);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      step(1'($urandom_range(0, 1)), b, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      if (i % 1000 == 999) do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
